// File: rtl/toggle_activity_counter_if.sv
// Bus bundle for toggle_activity_counter: the sample input port and the
// window-result valid/ready port.
//   smp_valid/smp_data : monitored bus sample (producer -> counter)
//   win_valid/win_ready: result handshake
//   win_count/win_index/win_sat/win_peak: result payload (counter -> consumer)
// slave modport is the counter side, master modport the producer/consumer side.
interface toggle_activity_counter_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned CW = 24
);
   localparam int unsigned PW = $clog2(DW + 1);

   logic          smp_valid;
   logic [DW-1:0] smp_data;
   logic          win_valid;
   logic          win_ready;
   logic [CW-1:0] win_count;
   logic [15:0]   win_index;
   logic          win_sat;
   logic [PW-1:0] win_peak;

   modport slave (
      input  smp_valid, smp_data, win_ready,
      output win_valid, win_count, win_index, win_sat, win_peak
   );

   modport master (
      output smp_valid, smp_data, win_ready,
      input  win_valid, win_count, win_index, win_sat, win_peak
   );
endinterface

// File: rtl/toggle_activity_counter.sv
// toggle_activity_counter: switching-activity monitor. Accumulates the Hamming
// distance between successive accepted samples over windows of WIN samples and
// offers each window total through a valid/ready result register.
// Ports:
//   clk1, rst_n (synchronous, active-low)
//   start, stop : single-cycle run control pulses
//   bus         : toggle_activity_counter_if.slave (samples in, window results out)
//   ovf         : sticky, a completed window was dropped
//   busy        : run active or pipeline occupied
// Optional feature: define TAC_PEAK_EN to report the per-window peak
// single-sample toggle count on win_peak (tied to 0 otherwise).
module toggle_activity_counter #(
   parameter int unsigned DW  = 32,
   parameter int unsigned CW  = 24,
   parameter int unsigned WIN = 256
) (
   input  logic                           clk1,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic                           stop,
   toggle_activity_counter_if.slave       bus,
   output logic                           ovf,
   output logic                           busy
);
   localparam int unsigned HW = $clog2(DW + 1);
   localparam int unsigned NW = $clog2(WIN);

   typedef enum logic [1:0] {IDLE, PRIME, RUN} state_e;

   function automatic logic [HW-1:0] popcnt(input logic [DW-1:0] v);
      logic [HW-1:0] n;
      n = '0;
      for (int i = 0; i < DW; i++) n = n + HW'(v[i]);
      return n;
   endfunction

   state_e        state_q, state_d;
   logic          cap_base, cap_smp, abort_run, begin_run;

   logic [DW-1:0] prev_q;
   logic [NW-1:0] cnt_q;
   logic [15:0]   widx_q;
   logic          smp_last;

   logic          x_vld_q, x_last_q;
   logic [DW-1:0] x_xor_q;
   logic [15:0]   x_idx_q;

   logic          a_vld_q, a_last_q;
   logic [HW-1:0] a_hd_q;
   logic [15:0]   a_idx_q;

   logic [CW-1:0] acc_q, acc_nx;
   logic          sat_q, sat_now;
   logic [CW:0]   sum;

   logic          keep_win, drop_win, x_go, b_go, b_last;

   logic          win_valid_q, win_sat_q, ovf_q, busy_q;
   logic [CW-1:0] win_count_q;
   logic [15:0]   win_index_q;

   // FSM state register
   always_ff @(posedge clk1) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next state and sample-acceptance control; stop outranks smp_valid
   always_comb begin
      state_d   = state_q;
      cap_base  = 1'b0;
      cap_smp   = 1'b0;
      abort_run = 1'b0;
      begin_run = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = PRIME;
               begin_run = 1'b1;
            end
         end
         PRIME: begin
            if (start || stop) begin
               state_d   = IDLE;
               abort_run = 1'b1;
            end else if (bus.smp_valid) begin
               state_d  = RUN;
               cap_base = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d   = IDLE;
               abort_run = 1'b1;
            end else if (bus.smp_valid) begin
               cap_smp = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign smp_last = (cnt_q == NW'(WIN - 1));

   // On abort, a window whose last sample is already in flight is allowed to
   // finish; everything else in flight and the partial accumulator is dropped.
   assign keep_win = (x_vld_q & x_last_q) | (a_vld_q & a_last_q);
   assign drop_win = abort_run & ~keep_win;
   assign x_go     = x_vld_q & (~abort_run | x_last_q);
   assign b_go     = a_vld_q & ~drop_win;
   assign b_last   = b_go & a_last_q;

   // Stage B saturating add
   assign sum     = {1'b0, acc_q} + (CW+1)'(a_hd_q);
   assign sat_now = sum[CW];
   assign acc_nx  = sat_now ? {CW{1'b1}} : sum[CW-1:0];

   // Sample capture: xor against previous sample, window position and index
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         prev_q   <= '0;
         cnt_q    <= '0;
         widx_q   <= '0;
         x_vld_q  <= 1'b0;
         x_last_q <= 1'b0;
         x_xor_q  <= '0;
         x_idx_q  <= '0;
      end else begin
         x_vld_q <= cap_smp;
         if (cap_base) prev_q <= bus.smp_data;
         if (cap_smp) begin
            prev_q   <= bus.smp_data;
            x_xor_q  <= bus.smp_data ^ prev_q;
            x_last_q <= smp_last;
            x_idx_q  <= widx_q;
            cnt_q    <= smp_last ? '0 : cnt_q + NW'(1);
            if (smp_last) widx_q <= widx_q + 16'd1;
         end
         if (begin_run) begin
            cnt_q  <= '0;
            widx_q <= '0;
         end
      end
   end

   // Stage A: per-sample toggle count
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         a_vld_q  <= 1'b0;
         a_last_q <= 1'b0;
         a_hd_q   <= '0;
         a_idx_q  <= '0;
      end else begin
         a_vld_q <= x_go;
         if (x_go) begin
            a_hd_q   <= popcnt(x_xor_q);
            a_last_q <= x_last_q;
            a_idx_q  <= x_idx_q;
         end
      end
   end

   // Stage B: window accumulator and per-window saturation flag
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else if (drop_win || b_last) begin
         acc_q <= '0;
         sat_q <= 1'b0;
      end else if (b_go) begin
         acc_q <= acc_nx;
         sat_q <= sat_q | sat_now;
      end
   end

   // Result register: a new result arriving while the old one is stuck is dropped
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         win_valid_q <= 1'b0;
         win_count_q <= '0;
         win_index_q <= '0;
         win_sat_q   <= 1'b0;
         ovf_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         if (begin_run) ovf_q <= 1'b0;
         if (b_last && win_valid_q && !bus.win_ready) begin
            ovf_q <= 1'b1;
         end else if (b_last) begin
            win_valid_q <= 1'b1;
            win_count_q <= acc_nx;
            win_index_q <= a_idx_q;
            win_sat_q   <= sat_q | sat_now;
         end else if (win_valid_q && bus.win_ready) begin
            win_valid_q <= 1'b0;
         end
         busy_q <= (state_q != IDLE) | x_vld_q | a_vld_q;
      end
   end

`ifdef TAC_PEAK_EN
   logic [HW-1:0] peak_q, peak_nx, win_peak_q;

   assign peak_nx = (a_hd_q > peak_q) ? a_hd_q : peak_q;

   // Peak compare alongside Stage B, result captured with win_count
   always_ff @(posedge clk1) begin
      if (!rst_n) begin
         peak_q     <= '0;
         win_peak_q <= '0;
      end else begin
         if (drop_win || b_last) peak_q <= '0;
         else if (b_go)          peak_q <= peak_nx;
         if (b_last && !(win_valid_q && !bus.win_ready)) win_peak_q <= peak_nx;
      end
   end

   assign bus.win_peak = win_peak_q;
`else
   assign bus.win_peak = '0;
`endif

   assign bus.win_valid = win_valid_q;
   assign bus.win_count = win_count_q;
   assign bus.win_index = win_index_q;
   assign bus.win_sat   = win_sat_q;
   assign ovf           = ovf_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_toggle_activity_counter.sv
// Bench for toggle_activity_counter: two instances (CW=24 and CW=6, WIN=4)
// share one stimulus stream; a window-level reference model queues expected
// results, and a negedge monitor checks every delivered window.
module tb_toggle_activity_counter;
   localparam int unsigned DW  = 32;
   localparam int unsigned WIN = 4;

   typedef struct {
      int     idx;
      longint tot;
      int     peak;
   } exp_t;

   logic        clk1 = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        smp_valid = 1'b0;
   logic [31:0] smp_data = '0;
   logic        win_ready = 1'b0;
   logic        ovf_a, busy_a, ovf_b, busy_b;

   int total = 0;
   int bad = 0;
   bit allow_drop = 1'b0;

   exp_t qa[$];
   exp_t qb[$];

   int          mode = 0;
   logic [31:0] mprev = '0;
   int          hds[$];
   int          widx = 0;

   bit          held[2];
   logic [23:0] h_cnt[2];
   logic [15:0] h_idx[2];
   int          last_idx_a = -1;
   longint      last_cnt_a = -1;
   int          last_pk_a = -1;

   toggle_activity_counter_if #(.DW(DW), .CW(24)) if_a ();
   toggle_activity_counter_if #(.DW(DW), .CW(6))  if_b ();

   assign if_a.smp_valid = smp_valid;
   assign if_a.smp_data  = smp_data;
   assign if_a.win_ready = win_ready;
   assign if_b.smp_valid = smp_valid;
   assign if_b.smp_data  = smp_data;
   assign if_b.win_ready = win_ready;

   toggle_activity_counter #(.DW(DW), .CW(24), .WIN(WIN)) dut_a (
      .clk1(clk1), .rst_n(rst_n), .start(start), .stop(stop),
      .bus(if_a), .ovf(ovf_a), .busy(busy_a)
   );

   toggle_activity_counter #(.DW(DW), .CW(6), .WIN(WIN)) dut_b (
      .clk1(clk1), .rst_n(rst_n), .start(start), .stop(stop),
      .bus(if_b), .ovf(ovf_b), .busy(busy_b)
   );

   always #5 clk1 = ~clk1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
      end
   endtask

   // Reference model: one call per clock cycle with that cycle's inputs
   function automatic void model(input logic st, input logic sp, input logic v,
                                 input logic [31:0] d);
      exp_t e;
      if (mode == 0) begin
         if (st) begin
            mode = 1;
            widx = 0;
            hds.delete();
         end
      end else if (sp || (mode == 1 && st)) begin
         mode = 0;
         hds.delete();
      end else if (v) begin
         if (mode == 1) begin
            mprev = d;
            mode  = 2;
         end else begin
            hds.push_back($countones(d ^ mprev));
            mprev = d;
            if (hds.size() == WIN) begin
               e.idx  = widx % 65536;
               e.tot  = 0;
               e.peak = 0;
               foreach (hds[i]) begin
                  e.tot += hds[i];
                  if (hds[i] > e.peak) e.peak = hds[i];
               end
               qa.push_back(e);
               qb.push_back(e);
               widx++;
               hds.delete();
            end
         end
      end
   endfunction

   task automatic cyc(input logic st, input logic sp, input logic v, input logic [31:0] d);
      start     = st;
      stop      = sp;
      smp_valid = v;
      smp_data  = d;
      model(st, sp, v, d);
      @(posedge clk1);
      #1;
   endtask

   function automatic int qsize(input int w);
      return (w == 0) ? qa.size() : qb.size();
   endfunction

   function automatic int qfront_idx(input int w);
      return (w == 0) ? qa[0].idx : qb[0].idx;
   endfunction

   function automatic exp_t qpop(input int w);
      if (w == 0) return qa.pop_front();
      return qb.pop_front();
   endfunction

   task automatic mon_port(input int w, input logic v, input logic r, input logic [23:0] c,
                           input logic [15:0] ix, input logic s, input logic [5:0] pk);
      exp_t   e;
      longint mx;
      longint ec;
      int     epk;
      string  p;
      p = (w == 0) ? "a" : "b";
      if (held[w]) begin
         chk({p, "_hold_valid"}, 64'(v), 64'd1);
         chk({p, "_hold_count"}, 64'(c), 64'(h_cnt[w]));
         chk({p, "_hold_index"}, 64'(ix), 64'(h_idx[w]));
      end
      if (v && r) begin
         if (qsize(w) == 0) begin
            chk({p, "_spurious_window"}, 64'(qsize(w)), 64'd1);
         end else begin
            while (allow_drop && qsize(w) > 1 && qfront_idx(w) != int'(ix)) e = qpop(w);
            e  = qpop(w);
            mx = (w == 0) ? 64'h00FF_FFFF : 64'd63;
            ec = (e.tot > mx) ? mx : e.tot;
`ifdef TAC_PEAK_EN
            epk = e.peak;
`else
            epk = 0;
`endif
            chk({p, "_win_index"}, 64'(ix), 64'(e.idx));
            chk({p, "_win_count"}, 64'(c), 64'(ec));
            chk({p, "_win_sat"}, 64'(s), 64'(e.tot > mx));
            chk({p, "_win_peak"}, 64'(pk), 64'(epk));
            if (w == 0) begin
               last_idx_a = int'(ix);
               last_cnt_a = longint'(c);
               last_pk_a  = int'(pk);
            end
         end
      end
      held[w]  = v && !r;
      h_cnt[w] = c;
      h_idx[w] = ix;
   endtask

   // Monitor: outputs are stable at negedge; valid&ready here handshakes next edge
   always @(negedge clk1) begin
      if (!rst_n) begin
         held[0] = 1'b0;
         held[1] = 1'b0;
      end else begin
         mon_port(0, if_a.win_valid, win_ready, if_a.win_count, if_a.win_index,
                  if_a.win_sat, if_a.win_peak);
         mon_port(1, if_b.win_valid, win_ready, 24'(if_b.win_count), if_b.win_index,
                  if_b.win_sat, if_b.win_peak);
      end
   end

   task automatic check_zero(input string tag);
      chk({tag, "_a_valid"}, 64'(if_a.win_valid), 64'd0);
      chk({tag, "_a_count"}, 64'(if_a.win_count), 64'd0);
      chk({tag, "_a_index"}, 64'(if_a.win_index), 64'd0);
      chk({tag, "_a_sat"},   64'(if_a.win_sat),   64'd0);
      chk({tag, "_a_peak"},  64'(if_a.win_peak),  64'd0);
      chk({tag, "_a_ovf"},   64'(ovf_a),          64'd0);
      chk({tag, "_a_busy"},  64'(busy_a),         64'd0);
      chk({tag, "_b_valid"}, 64'(if_b.win_valid), 64'd0);
      chk({tag, "_b_count"}, 64'(if_b.win_count), 64'd0);
      chk({tag, "_b_ovf"},   64'(ovf_b),          64'd0);
      chk({tag, "_b_busy"},  64'(busy_b),         64'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, $urandom);
   endtask

   initial begin
      logic [31:0] d;
      int          lowrun;
      int          k;
      int          tg[4];

      // reset state
      idle(3);
      check_zero("reset");
      rst_n = 1'b1;
      idle(2);

      // basic window with latency check, result held by ready low
      win_ready = 1'b0;
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, 32'h0);
      cyc(0, 0, 1, 32'hFFFF_FFFF);
      cyc(0, 0, 1, 32'h0);
      cyc(0, 0, 1, 32'hFFFF_FFFF);
      cyc(0, 0, 1, 32'h0);
      chk("lat_edge_t", 64'(if_a.win_valid), 64'd0);
      idle(1);
      chk("lat_edge_t1", 64'(if_a.win_valid), 64'd0);
      idle(1);
      chk("lat_edge_t2_a", 64'(if_a.win_valid), 64'd1);
      chk("lat_edge_t2_b", 64'(if_b.win_valid), 64'd1);
      win_ready = 1'b1;
      idle(2);
      chk("basic_count_a", 64'(last_cnt_a), 64'd128);
      cyc(0, 1, 0, 0);
      idle(2);

      // overflow: two windows while ready low, then release
      win_ready  = 1'b0;
      allow_drop = 1'b1;
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, $urandom);
      for (int i = 0; i < 8; i++) cyc(0, 0, 1, $urandom);
      idle(3);
      chk("ovf_set_a", 64'(ovf_a), 64'd1);
      chk("ovf_set_b", 64'(ovf_b), 64'd1);
      chk("ovf_held_index", 64'(if_a.win_index), 64'd0);
      win_ready = 1'b1;
      idle(1);
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, $urandom);
      idle(4);
      chk("ovf_gap_index", 64'(last_idx_a), 64'd2);
      allow_drop = 1'b0;
      cyc(0, 1, 0, 0);
      idle(1);

      // saturation window then zero-toggle window; start clears ovf
      cyc(1, 0, 0, 0);
      chk("ovf_clear_a", 64'(ovf_a), 64'd0);
      d = $urandom;
      cyc(0, 0, 1, d);
      for (int i = 0; i < 4; i++) begin
         d = ~d;
         cyc(0, 0, 1, d);
      end
      for (int i = 0; i < 4; i++) cyc(0, 0, 1, d);
      idle(4);
      cyc(0, 1, 0, 0);

      // stop mid-window: nothing delivered, busy drops, restart needs baseline
      cyc(1, 0, 0, 0);
      cyc(0, 0, 1, $urandom);
      cyc(0, 0, 1, $urandom);
      cyc(0, 0, 1, $urandom);
      chk("stop_busy_before", 64'(busy_a), 64'd1);
      cyc(0, 1, 1, $urandom);
      idle(3);
      chk("stop_busy_a", 64'(busy_a), 64'd0);
      chk("stop_busy_b", 64'(busy_b), 64'd0);
      chk("stop_no_valid", 64'(if_a.win_valid), 64'd0);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, $urandom);
      idle(4);
      chk("restart_index", 64'(last_idx_a), 64'd0);
      cyc(0, 1, 0, 0);

      // bubbles between samples, with junk data on the bubble cycles
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 9; i++) begin
         cyc(0, 0, 1, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'h0);
         k = $urandom_range(0, 2);
         for (int j = 0; j < k; j++) cyc(0, 0, 0, $urandom);
      end
      idle(4);
      chk("bubble_count_a", 64'(last_cnt_a), 64'd128);
      cyc(0, 1, 0, 0);

      // peak window: per-sample toggles 3, 17, 5, 1
      tg[0] = 3; tg[1] = 17; tg[2] = 5; tg[3] = 1;
      cyc(1, 0, 0, 0);
      d = 32'h0;
      cyc(0, 0, 1, d);
      for (int i = 0; i < 4; i++) begin
         d = d ^ (32'hFFFF_FFFF >> (32 - tg[i]));
         cyc(0, 0, 1, d);
      end
      idle(4);
      chk("peak_count", 64'(last_cnt_a), 64'd26);
`ifdef TAC_PEAK_EN
      chk("peak_value", 64'(last_pk_a), 64'd17);
`else
      chk("peak_value", 64'(last_pk_a), 64'd0);
`endif
      cyc(0, 1, 0, 0);

      // randomized run; ready low never lasts long enough to force a drop
      lowrun = 0;
      for (int i = 0; i < 1500; i++) begin
         if (lowrun >= 2) win_ready = 1'b1;
         else             win_ready = ($urandom_range(0, 3) != 0);
         lowrun = win_ready ? 0 : lowrun + 1;
         if ($urandom_range(0, 1) == 1) d = $urandom;
         else                           d = d ^ (32'h1 << $urandom_range(0, 31));
         cyc(($urandom_range(0, 99) < 3), ($urandom_range(0, 199) < 2),
             ($urandom_range(0, 9) < 7), d);
      end
      win_ready = 1'b1;
      cyc(0, 1, 0, 0);
      for (int i = 0; i < 40 && (qa.size() != 0 || qb.size() != 0); i++) idle(1);
      chk("drain_a", 64'(qa.size()), 64'd0);
      chk("drain_b", 64'(qb.size()), 64'd0);
      chk("random_ovf_a", 64'(ovf_a), 64'd0);

      // reset while a result is pending
      win_ready = 1'b0;
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, $urandom);
      idle(3);
      chk("pend_valid", 64'(if_a.win_valid), 64'd1);
      rst_n = 1'b0;
      qa.delete();
      qb.delete();
      mode = 0;
      hds.delete();
      @(posedge clk1);
      #1;
      check_zero("midreset");
      rst_n = 1'b1;
      idle(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
